// File: rtl/ntt_seq_pkg.sv
// Shared types and width helpers for the NTT pass sequencer.
// Sizes that every file needs are derived here so that they cannot drift apart.
package ntt_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        DRAIN,
        SCALE,
        FIN
    } state_e;

    function automatic int widx_width(input int lut_size);
        return (lut_size > 1) ? $clog2(lut_size) : 1;
    endfunction

    // The counter must be able to hold RD_LAT+BF_LAT rows in flight at once.
    function automatic int infl_width(input int rd_lat, input int bf_lat);
        return $clog2(rd_lat + bf_lat + 1);
    endfunction

endpackage

// File: rtl/ntt_pass_sequencer_if.sv
// Configuration, memory-read, array-tag and write-back signals of the pass sequencer.
// The sequencer drives through the master modport; its environment uses slave.
interface ntt_pass_sequencer_if #(
    parameter int ADDR_W   = 8,
    parameter int LUT_SIZE = 1360,
    parameter int STG_W    = 5
) ();
    import ntt_seq_pkg::*;

    localparam int WIDX_W = widx_width(LUT_SIZE);

    logic              start;
    logic [STG_W-1:0]  n_stages;
    logic [ADDR_W:0]   n_rows;
    logic [WIDX_W-1:0] w_base;
    logic              scale_en;
    logic [WIDX_W-1:0] scale_idx;
    logic              scale_swap;
    logic              hold;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mode;
    logic              swap;
    logic [WIDX_W-1:0] w_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, n_stages, n_rows, w_base, scale_en, scale_idx, scale_swap, hold,
        output rd_en, rd_addr, mode, swap, w_idx, wr_en, wr_addr, busy, done, err
    );

    modport slave (
        output start, n_stages, n_rows, w_base, scale_en, scale_idx, scale_swap, hold,
        input  rd_en, rd_addr, mode, swap, w_idx, wr_en, wr_addr, busy, done, err
    );

endinterface

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register carrying a valid bit alongside a W-bit payload.
// Used to align array tags and write-back rows with the issued reads.
module ntt_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            // NOTE: payload stages are cleared too, so every output reads 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make each stage take its neighbour's old value,
            // which is exactly one cycle of delay per stage.
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/ntt_pass_sequencer.sv
// Walks the coefficient memory stage by stage for the butterfly array, tags each row,
// strobes write-back when the array output emerges, and drains between in-place passes.
module ntt_pass_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int LUT_SIZE = 1360,
    parameter int RD_LAT   = 1,
    parameter int BF_LAT   = 4,
    parameter int STG_W    = 5
) (
    input logic                  clk,
    input logic                  reset,
    ntt_pass_sequencer_if.master bus
);

    localparam int WIDX_W = widx_width(LUT_SIZE);
    localparam int INFL_W = infl_width(RD_LAT, BF_LAT);
    localparam int TAG_W  = WIDX_W + 2;
    localparam int PROD_W = STG_W + ADDR_W + 1;
    localparam int CHK_W  = ((PROD_W > WIDX_W) ? PROD_W : WIDX_W) + 1;

    state_e            state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [WIDX_W-1:0] w_acc_q, w_acc_d;
    logic              scale_done_q, scale_done_d;
    logic [INFL_W-1:0] infl_q, infl_d;
    logic [TAG_W-1:0]  tag_last_q;

    logic [STG_W-1:0]  n_stages_q;
    logic [ADDR_W:0]   n_rows_q;
    logic [WIDX_W-1:0] w_base_q;
    logic              scale_en_q;
    logic [WIDX_W-1:0] scale_idx_q;
    logic              scale_swap_q;

    logic              cfg_ld;
    logic              cfg_bad;
    logic              no_work;
    logic              last_row;
    logic [STG_W:0]    stage_nxt;
    logic [CHK_W-1:0]  work_end;

    logic              issue;
    logic              tag_mode;
    logic              tag_swap;
    logic [WIDX_W-1:0] tag_widx;
    logic              tag_v;
    logic [TAG_W-1:0]  tag_out;
    logic [TAG_W-1:0]  tag_cur;
    logic              wr_v;
    logic [ADDR_W-1:0] wr_row;
    logic              busy;
    logic              done;
    logic              err;

    assign cfg_ld    = (state_q == IDLE) && bus.start;
    // Full-width sum, so an oversized request can never wrap past the table end.
    assign work_end  = CHK_W'(w_base_q) + CHK_W'(n_stages_q) * CHK_W'(n_rows_q);
    assign cfg_bad   = (work_end > CHK_W'(LUT_SIZE)) ||
                       (scale_en_q && (CHK_W'(scale_idx_q) >= CHK_W'(LUT_SIZE)));
    assign no_work   = (n_rows_q == '0) || ((n_stages_q == '0) && !scale_en_q);
    assign last_row  = ({1'b0, row_q} == (n_rows_q - 1'b1));
    assign stage_nxt = {1'b0, stage_q} + 1'b1;

    always_comb begin
        // NOTE: every signal gets its default before the case, so no path can infer a latch.
        state_d      = state_q;
        stage_d      = stage_q;
        row_d        = row_q;
        w_acc_d      = w_acc_q;
        scale_done_d = scale_done_q;
        issue        = 1'b0;
        tag_mode     = 1'b0;
        tag_swap     = 1'b0;
        tag_widx     = w_acc_q;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                busy         = 1'b1;
                stage_d      = '0;
                row_d        = '0;
                w_acc_d      = w_base_q;
                scale_done_d = 1'b0;
                if (cfg_bad) begin
                    err     = 1'b1;
                    busy    = 1'b0;
                    state_d = IDLE;
                end else if (no_work) begin
                    state_d = FIN;
                end else if (n_stages_q == '0) begin
                    state_d = SCALE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE, SCALE: begin
                busy = 1'b1;
                if (state_q == SCALE) begin
                    tag_mode = 1'b1;
                    tag_swap = scale_swap_q;
                    tag_widx = scale_idx_q;
                end
                if (!bus.hold) begin
                    issue = 1'b1;
                    row_d = row_q + 1'b1;
                    if (state_q == ISSUE) begin
                        w_acc_d = w_acc_q + 1'b1;
                    end
                    if (last_row) begin
                        row_d   = '0;
                        state_d = DRAIN;
                        if (state_q == SCALE) begin
                            scale_done_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (infl_q == '0) begin
                    if (stage_nxt < {1'b0, n_stages_q} && !scale_done_q) begin
                        stage_d = stage_nxt[STG_W-1:0];
                        state_d = ISSUE;
                    end else if (scale_en_q && !scale_done_q) begin
                        state_d = SCALE;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        unique case ({issue, wr_v})
            2'b10:   infl_d = infl_q + 1'b1;
            2'b01:   infl_d = infl_q - 1'b1;
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            row_q        <= '0;
            w_acc_q      <= '0;
            scale_done_q <= 1'b0;
            infl_q       <= '0;
            tag_last_q   <= '0;
            n_stages_q   <= '0;
            n_rows_q     <= '0;
            w_base_q     <= '0;
            scale_en_q   <= 1'b0;
            scale_idx_q  <= '0;
            scale_swap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            row_q        <= row_d;
            w_acc_q      <= w_acc_d;
            scale_done_q <= scale_done_d;
            infl_q       <= infl_d;
            if (tag_v) begin
                tag_last_q <= tag_out;
            end
            if (cfg_ld) begin
                n_stages_q   <= bus.n_stages;
                n_rows_q     <= bus.n_rows;
                w_base_q     <= bus.w_base;
                scale_en_q   <= bus.scale_en;
                scale_idx_q  <= bus.scale_idx;
                scale_swap_q <= bus.scale_swap;
            end
        end
    end

    ntt_delay_line #(
        .DEPTH (RD_LAT),
        .W     (TAG_W)
    ) u_tag_dly (
        .clk     (clk),
        .rst_n   (reset),
        .valid_i (issue),
        .data_i  ({tag_mode, tag_swap, tag_widx}),
        .valid_o (tag_v),
        .data_o  (tag_out)
    );

    ntt_delay_line #(
        .DEPTH (RD_LAT + BF_LAT),
        .W     (ADDR_W)
    ) u_wr_dly (
        .clk     (clk),
        .rst_n   (reset),
        .valid_i (issue),
        .data_i  (row_q),
        .valid_o (wr_v),
        .data_o  (wr_row)
    );

    // Tags hold their last presented value between issues.
    assign tag_cur     = tag_v ? tag_out : tag_last_q;

    assign bus.rd_en   = issue;
    assign bus.rd_addr = row_q;
    assign bus.mode    = tag_cur[TAG_W-1];
    assign bus.swap    = tag_cur[TAG_W-2];
    assign bus.w_idx   = tag_cur[WIDX_W-1:0];
    assign bus.wr_en   = wr_v;
    assign bus.wr_addr = wr_row;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.err     = err;

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Scoreboard bench for ntt_pass_sequencer: reads, tags and write-backs are predicted
// from the job configuration and checked cycle by cycle as the DUT produces them.
module tb_ntt_pass_sequencer;
    import ntt_seq_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int LUT_SIZE = 1360;
    localparam int RD_LAT   = 1;
    localparam int BF_LAT   = 4;
    localparam int STG_W    = 5;
    localparam int WIDX_W   = widx_width(LUT_SIZE);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              mode;
        logic              swap;
        logic [WIDX_W-1:0] widx;
    } rd_t;

    typedef struct {
        int  due;
        rd_t r;
    } pend_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;

    rd_t   exp_rd[$];
    pend_t tag_pend[$];
    pend_t wr_pend[$];
    rd_t   mon_r;
    pend_t mon_p;
    bit    mon_wr_exp;

    ntt_pass_sequencer_if #(
        .ADDR_W   (ADDR_W),
        .LUT_SIZE (LUT_SIZE),
        .STG_W    (STG_W)
    ) bus ();

    ntt_pass_sequencer #(
        .ADDR_W   (ADDR_W),
        .LUT_SIZE (LUT_SIZE),
        .RD_LAT   (RD_LAT),
        .BF_LAT   (BF_LAT),
        .STG_W    (STG_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint outs();
        return longint'({bus.rd_en, bus.rd_addr, bus.mode, bus.swap, bus.w_idx,
                         bus.wr_en, bus.wr_addr, bus.busy, bus.done, bus.err});
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.rd_en) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                mon_r = exp_rd.pop_front();
                check("rd_addr", bus.rd_addr, mon_r.addr);
                if (mon_r.addr == '0) begin
                    check("drain_before_pass", wr_cnt, rd_cnt);
                end
                tag_pend.push_back('{due: cyc + RD_LAT, r: mon_r});
                wr_pend.push_back('{due: cyc + RD_LAT + BF_LAT, r: mon_r});
            end
            rd_cnt++;
        end
        if (tag_pend.size() > 0 && tag_pend[0].due == cyc) begin
            mon_p = tag_pend.pop_front();
            check("tag_mode", bus.mode, mon_p.r.mode);
            check("tag_swap", bus.swap, mon_p.r.swap);
            check("tag_widx", bus.w_idx, mon_p.r.widx);
        end
        mon_wr_exp = (wr_pend.size() > 0) && (wr_pend[0].due == cyc);
        check("wr_en", bus.wr_en, mon_wr_exp);
        if (mon_wr_exp) begin
            mon_p = wr_pend.pop_front();
            if (bus.wr_en) begin
                check("wr_addr", bus.wr_addr, mon_p.r.addr);
            end
        end
        if (bus.wr_en) wr_cnt++;
        if (bus.hold) check("hold_rd", bus.rd_en, 0);
    end

    task automatic drive_cfg(input int ns, input int nr, input int wb, input bit sen,
                             input int sidx, input bit ssw);
        bus.n_stages   = STG_W'(ns);
        bus.n_rows     = (ADDR_W + 1)'(nr);
        bus.w_base     = WIDX_W'(wb);
        bus.scale_en   = sen;
        bus.scale_idx  = WIDX_W'(sidx);
        bus.scale_swap = ssw;
    endtask

    task automatic push_reads(input int ns, input int nr, input int wb, input bit sen,
                              input int sidx, input bit ssw);
        for (int st = 0; st < ns; st++) begin
            for (int r = 0; r < nr; r++) begin
                exp_rd.push_back('{addr: ADDR_W'(r), mode: 1'b0, swap: 1'b0,
                                   widx: WIDX_W'(wb + st * nr + r)});
            end
        end
        if (sen) begin
            for (int r = 0; r < nr; r++) begin
                exp_rd.push_back('{addr: ADDR_W'(r), mode: 1'b1, swap: ssw,
                                   widx: WIDX_W'(sidx)});
            end
        end
    endtask

    task automatic run_job(input int ns, input int nr, input int wb, input bit sen,
                           input int sidx, input bit ssw, input int hold_a,
                           input int hold_b, input int restart_k);
        int s;
        int exp_len;
        int passes;
        int nholds;
        bit bad;
        bit idle_job;
        bit ended;
        bad      = (wb + ns * nr > LUT_SIZE) || (sen && sidx >= LUT_SIZE);
        idle_job = (nr == 0) || (ns == 0 && !sen);
        passes   = ns + (sen ? 1 : 0);
        nholds   = ((hold_a > 0) ? 1 : 0) + ((hold_b > 0) ? 1 : 0);
        if (bad)           exp_len = 1;
        else if (idle_job) exp_len = 2;
        else               exp_len = 2 + passes * (nr + RD_LAT + BF_LAT + 1) + nholds;
        if (!bad && !idle_job) push_reads(ns, nr, wb, sen, sidx, ssw);
        rd_cnt = 0;
        wr_cnt = 0;

        @(posedge clk); #1;
        drive_cfg(ns, nr, wb, sen, sidx, ssw);
        bus.start = 1'b1;
        s = cyc;
        ended = 1'b0;
        for (int k = 1; k <= 600 && !ended; k++) begin
            @(posedge clk); #1;
            bus.start = (k == restart_k);
            if (k == restart_k) drive_cfg(1, 3, 0, 1'b0, 0, 1'b0);
            bus.hold = (k == hold_a) || (k == hold_b);
            @(negedge clk);
            if (bus.done || bus.err) ended = 1'b1;
            else check("busy_run", bus.busy, 1);
        end
        check("finished", ended, 1);
        check("end_cycle", cyc - s, exp_len);
        check("err_pulse", bus.err, bad);
        check("done_pulse", bus.done, !bad);
        check("busy_at_end", bus.busy, 0);

        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        @(negedge clk);
        check("busy_after", bus.busy, 0);
        check("done_once", bus.done, 0);
        check("err_once", bus.err, 0);
        check("reads_left", exp_rd.size(), 0);
        check("writes_left", wr_pend.size(), 0);
    endtask

    task automatic reset_midflight();
        push_reads(2, 4, 10, 1'b0, 0, 1'b0);
        rd_cnt = 0;
        wr_cnt = 0;
        @(posedge clk); #1;
        drive_cfg(2, 4, 10, 1'b0, 0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("inflight_reads", rd_cnt, 3);
        check("inflight_no_wr", wr_cnt, 0);
        reset = 1'b0;
        exp_rd.delete();
        tag_pend.delete();
        wr_pend.delete();
        #1;
        check("reset_outs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_wr_after_reset", wr_cnt, 0);
        check("idle_after_reset", outs(), 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        drive_cfg(0, 0, 0, 1'b0, 0, 1'b0);
        #1;
        check("reset_state", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_state", outs(), 0);

        run_job(2, 4, 10, 1'b0, 0, 1'b0, 0, 0, 8);      // two passes, late start ignored
        run_job(2, 4, 10, 1'b0, 0, 1'b0, 3, 4, 0);      // hold on 2nd and 3rd issue cycles
        run_job(1, 2, 0, 1'b1, 1359, 1'b1, 0, 0, 0);    // appended multiply pass
        run_job(1, 16, 1350, 1'b0, 0, 1'b0, 0, 0, 0);   // exceeds twiddle table
        run_job(1, 10, 1350, 1'b0, 0, 1'b0, 0, 0, 0);   // ends exactly at table size
        run_job(1, 2, 0, 1'b1, 1360, 1'b0, 0, 0, 0);    // scale index out of range
        run_job(1, 256, 0, 1'b0, 0, 1'b0, 0, 0, 0);     // full row range
        reset_midflight();
        run_job(2, 4, 10, 1'b0, 0, 1'b0, 0, 0, 0);
        run_job(2, 0, 10, 1'b0, 0, 1'b0, 0, 0, 1);      // no work, start during busy

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
